flit_injector: RTL and testbench

//  Injection stage of the minimal bufferless deflection router; the inbound counterpart of the ejector.

---
 rtl/router_pkg.sv | 19 +
 rtl/inj_fifo.sv | 54 +++++
 rtl/flit_injector.sv | 140 ++++++++++++++
 tb/tb_flit_injector.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared definitions for the deflection router: flit width, lane indices and
// the injection starvation state encoding.
package router_pkg;

  localparam int FLIT_W    = 11;
  localparam int NUM_LANES = 4;

  localparam int LANE_N = 0;
  localparam int LANE_E = 1;
  localparam int LANE_S = 2;
  localparam int LANE_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_STARVE = 2'd2
  } starve_state_t;

endpackage

// File: rtl/inj_fifo.sv
// Injection queue: power-of-two ring buffer with occupancy count and no
// push-to-pop bypass, so a pushed flit becomes the head on the following cycle.
module inj_fifo
  import router_pkg::*;
#(
  parameter int W     = FLIT_W,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  output logic [W-1:0]  rd_data,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // Full blocks pushes even when a pop frees a slot in the same cycle.
  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/flit_injector.sv
// Injection stage: queues local flits and drops the queue head into the first
// empty lane (N>E>S>W), flagging starvation when the head stays blocked.
module flit_injector
  import router_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLIT_W-1:0] nad_i,
  input  logic [FLIT_W-1:0] ead_i,
  input  logic [FLIT_W-1:0] sad_i,
  input  logic [FLIT_W-1:0] wad_i,
  input  logic              nvld_i,
  input  logic              evld_i,
  input  logic              svld_i,
  input  logic              wvld_i,
  output logic [FLIT_W-1:0] nad_o,
  output logic [FLIT_W-1:0] ead_o,
  output logic [FLIT_W-1:0] sad_o,
  output logic [FLIT_W-1:0] wad_o,
  output logic              nvld_o,
  output logic              evld_o,
  output logic              svld_o,
  output logic              wvld_o,
  input  logic [FLIT_W-1:0] inj_flit,
  input  logic              inj_valid,
  output logic              inj_ready,
  output logic              starve_o,
  output logic [CW-1:0]     fifo_cnt,
  output starve_state_t     starve_state
);

  // Handshake: a flit transfers on a rising edge where inj_valid && inj_ready;
  // inj_ready depends only on the registered count, never on inj_valid.

  logic [NUM_LANES-1:0] lane_vld_in;
  logic [FLIT_W-1:0]    lane_ad_in [NUM_LANES];
  logic [NUM_LANES-1:0] lane_vld_q;
  logic [FLIT_W-1:0]    lane_ad_q  [NUM_LANES];
  logic [NUM_LANES-1:0] sel;
  logic [FLIT_W-1:0]    head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 push_acc;
  logic                 blocked;
  starve_state_t        st_q, st_d;
  logic [7:0]           ctr_q, ctr_d;

  assign lane_vld_in[LANE_N] = nvld_i;
  assign lane_vld_in[LANE_E] = evld_i;
  assign lane_vld_in[LANE_S] = svld_i;
  assign lane_vld_in[LANE_W] = wvld_i;
  assign lane_ad_in[LANE_N]  = nad_i;
  assign lane_ad_in[LANE_E]  = ead_i;
  assign lane_ad_in[LANE_S]  = sad_i;
  assign lane_ad_in[LANE_W]  = wad_i;

  assign inj_ready = ~full;
  assign push_acc  = inj_valid & inj_ready;
  assign pop       = ~empty & ~(&lane_vld_in);
  assign blocked   = ~empty & (&lane_vld_in);

  inj_fifo #(.W(FLIT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (inj_valid),
    .wr_data (inj_flit),
    .pop     (pop),
    .rd_data (head),
    .cnt     (fifo_cnt),
    .full    (full),
    .empty   (empty)
  );

  // One-hot pick of the lowest-index free lane, only when a pop happens.
  always_comb begin
    sel = '0;
    if (pop) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (!lane_vld_in[i] && sel == '0) sel[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_vld_q <= '0;
      for (int i = 0; i < NUM_LANES; i++) lane_ad_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_vld_q[i] <= lane_vld_in[i] | sel[i];
        if (lane_vld_in[i])  lane_ad_q[i] <= lane_ad_in[i];
        else if (sel[i])     lane_ad_q[i] <= head;
      end
    end
  end

  assign nvld_o = lane_vld_q[LANE_N];
  assign evld_o = lane_vld_q[LANE_E];
  assign svld_o = lane_vld_q[LANE_S];
  assign wvld_o = lane_vld_q[LANE_W];
  assign nad_o  = lane_ad_q[LANE_N];
  assign ead_o  = lane_ad_q[LANE_E];
  assign sad_o  = lane_ad_q[LANE_S];
  assign wad_o  = lane_ad_q[LANE_W];

  // Once the counter reaches the limit it stays there, so STARVE holds until a pop.
  always_comb begin
    st_d  = st_q;
    ctr_d = ctr_q;
    if (pop) begin
      ctr_d = '0;
      st_d  = (fifo_cnt == CW'(1) && !push_acc) ? ST_IDLE : ST_WAIT;
    end else if (blocked) begin
      if (ctr_q != 8'hFF) ctr_d = ctr_q + 8'd1;
      st_d = (ctr_d >= 8'(STARVE_LIMIT)) ? ST_STARVE : ST_WAIT;
    end else begin
      ctr_d = '0;
      st_d  = push_acc ? ST_WAIT : ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q  <= ST_IDLE;
      ctr_q <= '0;
    end else begin
      st_q  <= st_d;
      ctr_q <= ctr_d;
    end
  end

  assign starve_o     = (st_q == ST_STARVE);
  assign starve_state = st_q;

endmodule

// File: tb/tb_flit_injector.sv
// Directed bench for flit_injector: reset, injection latency, lane priority,
// FIFO full/wrap ordering and starvation signalling.
module tb_flit_injector;
  import router_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [FLIT_W-1:0] nad_i, ead_i, sad_i, wad_i;
  logic              nvld_i, evld_i, svld_i, wvld_i;
  logic [FLIT_W-1:0] nad_o, ead_o, sad_o, wad_o;
  logic              nvld_o, evld_o, svld_o, wvld_o;
  logic [FLIT_W-1:0] inj_flit;
  logic              inj_valid;
  logic              inj_ready;
  logic              starve_o;
  logic [2:0]        fifo_cnt;
  starve_state_t     starve_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [FLIT_W-1:0] exp_q[$];
  logic [FLIT_W-1:0] exp_flit;

  flit_injector #(.DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .nad_i        (nad_i),
    .ead_i        (ead_i),
    .sad_i        (sad_i),
    .wad_i        (wad_i),
    .nvld_i       (nvld_i),
    .evld_i       (evld_i),
    .svld_i       (svld_i),
    .wvld_i       (wvld_i),
    .nad_o        (nad_o),
    .ead_o        (ead_o),
    .sad_o        (sad_o),
    .wad_o        (wad_o),
    .nvld_o       (nvld_o),
    .evld_o       (evld_o),
    .svld_o       (svld_o),
    .wvld_o       (wvld_o),
    .inj_flit     (inj_flit),
    .inj_valid    (inj_valid),
    .inj_ready    (inj_ready),
    .starve_o     (starve_o),
    .fifo_cnt     (fifo_cnt),
    .starve_state (starve_state)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mask bit0=N, bit1=E, bit2=S, bit3=W
  task automatic set_lanes(input logic [3:0] m, input logic [FLIT_W-1:0] an,
                           input logic [FLIT_W-1:0] ae, input logic [FLIT_W-1:0] as_,
                           input logic [FLIT_W-1:0] aw);
    nvld_i = m[0]; evld_i = m[1]; svld_i = m[2]; wvld_i = m[3];
    nad_i = an; ead_i = ae; sad_i = as_; wad_i = aw;
  endtask

  task automatic offer(input logic v, input logic [FLIT_W-1:0] f);
    inj_valid = v;
    inj_flit  = f;
  endtask

  initial begin
    rst_n = 1'b0;
    set_lanes(4'b0000, '0, '0, '0, '0);
    offer(1'b0, '0);
    tick();
    tick();
    check("rst_nvld", nvld_o, 0);
    check("rst_wvld", wvld_o, 0);
    check("rst_cnt", fifo_cnt, 0);
    check("rst_ready", inj_ready, 1);
    check("rst_starve", starve_o, 0);
    rst_n = 1'b1;

    // basic inject: flit appears on N two edges after the push is offered
    offer(1'b1, 11'h124);
    tick();
    check("basic_cnt1", fifo_cnt, 1);
    check("basic_nvld_early", nvld_o, 0);
    offer(1'b0, '0);
    tick();
    check("basic_nvld", nvld_o, 1);
    check("basic_nad", nad_o, 11'h124);
    check("basic_cnt0", fifo_cnt, 0);
    tick();
    check("basic_nvld_clr", nvld_o, 0);
    check("basic_nad_hold", nad_o, 11'h124);

    // priority: N,E busy -> S receives head; W holds last value
    set_lanes(4'b1111, 11'h011, 11'h022, 11'h033, 11'h044);
    offer(1'b1, 11'h0A5);
    tick();
    check("prio_cnt1", fifo_cnt, 1);
    check("prio_pass_n", nad_o, 11'h011);
    offer(1'b0, '0);
    set_lanes(4'b0011, 11'h111, 11'h222, 11'h033, 11'h044);
    tick();
    check("prio_svld", svld_o, 1);
    check("prio_sad", sad_o, 11'h0A5);
    check("prio_nad", nad_o, 11'h111);
    check("prio_ead", ead_o, 11'h222);
    check("prio_nvld", nvld_o, 1);
    check("prio_wvld", wvld_o, 0);
    check("prio_wad_hold", wad_o, 11'h044);
    check("prio_cnt0", fifo_cnt, 0);

    // starvation: head blocked for 10 cycles, then W frees
    set_lanes(4'b1111, 11'h011, 11'h022, 11'h033, 11'h044);
    offer(1'b1, 11'h155);
    tick();
    offer(1'b0, '0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("starve_k%0d", k), starve_o, (k >= 8) ? 1 : 0);
    end
    check("starve_state", starve_state, ST_STARVE);
    set_lanes(4'b0111, 11'h011, 11'h022, 11'h033, 11'h044);
    tick();
    check("starve_wvld", wvld_o, 1);
    check("starve_wad", wad_o, 11'h155);
    check("starve_clear", starve_o, 0);
    check("starve_idle", starve_state, ST_IDLE);
    check("starve_cnt", fifo_cnt, 0);

    // full: five pushes with all lanes busy, fifth rejected
    set_lanes(4'b1111, 11'h011, 11'h022, 11'h033, 11'h044);
    for (int i = 0; i < 5; i++) begin
      offer(1'b1, FLIT_W'(11'h301 + i));
      tick();
      check($sformatf("full_cnt%0d", i), fifo_cnt, (i < 4) ? i + 1 : 4);
      check($sformatf("full_ready%0d", i), inj_ready, (i < 3) ? 1 : 0);
    end
    for (int i = 0; i < 8; i++) exp_q.push_back(FLIT_W'(11'h301 + i));

    // push+pop while full, then wrap: flits 301..308 leave N in order
    set_lanes(4'b1110, 11'h000, 11'h022, 11'h033, 11'h044);
    offer(1'b1, 11'h305);
    tick();
    check("wrap_ready", inj_ready, 1);
    check("wrap_cnt_a", fifo_cnt, 3);
    exp_flit = exp_q.pop_front();
    check("wrap_nad_a", nad_o, exp_flit);
    for (int i = 1; i < 8; i++) begin
      if (i <= 4) offer(1'b1, FLIT_W'(11'h304 + i));
      else        offer(1'b0, '0);
      tick();
      exp_flit = exp_q.pop_front();
      check($sformatf("wrap_nvld%0d", i), nvld_o, 1);
      check($sformatf("wrap_nad%0d", i), nad_o, exp_flit);
      check($sformatf("wrap_cnt%0d", i), fifo_cnt, (i <= 4) ? 3 : 7 - i);
    end

    // reset mid-stream with three flits queued
    set_lanes(4'b1111, 11'h011, 11'h022, 11'h033, 11'h044);
    for (int i = 0; i < 3; i++) begin
      offer(1'b1, FLIT_W'(11'h3A1 + i));
      tick();
    end
    offer(1'b0, '0);
    check("pre_rst_cnt", fifo_cnt, 3);
    check("pre_rst_nvld", nvld_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_nvld", nvld_o, 0);
    check("mid_rst_evld", evld_o, 0);
    check("mid_rst_svld", svld_o, 0);
    check("mid_rst_wvld", wvld_o, 0);
    check("mid_rst_cnt", fifo_cnt, 0);
    check("mid_rst_ready", inj_ready, 1);
    check("mid_rst_starve", starve_o, 0);
    tick();
    rst_n = 1'b1;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
